// File: rtl/atm_entry_pkg.sv
// Shared encodings for the ATM keypad entry front-end: FSM states, key codes,
// operation codes, field limits and the request bundle presented to the core.
package atm_entry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_PIN  = 3'd2,
        ST_OP   = 3'd3,
        ST_AMT  = 3'd4,
        ST_NPIN = 3'd5,
        ST_REQ  = 3'd6
    } entry_state_t;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam logic [2:0] OP_BAL   = 3'd3;
    localparam logic [2:0] OP_WDRAW = 3'd4;
    localparam logic [2:0] OP_DEP   = 3'd5;
    localparam logic [2:0] OP_CHPIN = 3'd6;
    localparam logic [2:0] OP_EXIT  = 3'd7;

    localparam int ACC_MAX    = 15;
    localparam int AMT_MAX    = 65535;
    localparam int ACC_DIGITS = 2;
    localparam int OP_DIGITS  = 1;
    localparam int CNT_W      = 4;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [13:0] pin;
        logic [15:0] amount;
        logic [13:0] new_pin;
        logic        lang;
    } entry_req_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_field_accumulator.sv
// Decimal field accumulator shared by every keypad field: value = value*10 + digit,
// with a digit-count limit supplied by the current field.
module bcd_field_accumulator
    import atm_entry_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_digit_vld,
    input  logic [3:0]       i_digit,
    input  logic [CNT_W-1:0] i_max_digits,
    output logic [16:0]      o_value,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    logic [16:0]      r_value;
    logic [CNT_W-1:0] r_count;

    // Overflow means the next digit would exceed the field's limit and must be dropped.
    assign o_overflow = (r_count >= i_max_digits);
    assign o_value    = r_value;
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_digit_vld && !o_overflow) begin
            r_value <= (r_value << 3) + (r_value << 1) + {13'd0, i_digit};
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry FSM: assembles account/PIN/op/amount/new-PIN and hands one request to
// the ATM core over valid/ready. Define ATM_ENTRY_TIMEOUT_EN for the inactivity abort.
module atm_keypad_entry
    import atm_entry_pkg::*;
#(
    parameter int PIN_DIGITS     = 4,
    parameter int AMT_MAX_DIGITS = 5,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        language_sel,
    input  logic        req_ready,
    output logic        req_valid,
    output logic [2:0]  operation,
    output logic [3:0]  acc_num,
    output logic [13:0] pin,
    output logic [15:0] amount,
    output logic [13:0] new_pin,
    output logic        language,
    output logic [2:0]  entry_state,
    output logic        entry_error,
    output logic        timeout_pulse
);

    entry_state_t     r_state;
    entry_req_t       r_req;
    logic             r_req_valid;
    logic             r_err;
    logic             r_tmo;

    logic             w_digit;
    logic             w_in_field;
    logic             w_clr;
    logic             w_pass;
    logic             w_tmo;
    logic             w_ovf;
    logic [16:0]      w_val;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_max;

    assign w_digit    = key_valid && is_digit(key_code);
    assign w_in_field = (r_state != ST_IDLE) && (r_state != ST_REQ);
    // ENTER clears on both pass and fail so the next field starts from zero.
    assign w_clr      = w_tmo || (key_valid && w_in_field &&
                        (key_code == KEY_ENTER || key_code == KEY_CLEAR || key_code == KEY_CANCEL));

    always_comb begin
        w_max = CNT_W'(PIN_DIGITS);
        case (r_state)
            ST_IDLE, ST_ACC: w_max = CNT_W'(ACC_DIGITS);
            ST_OP:           w_max = CNT_W'(OP_DIGITS);
            ST_AMT:          w_max = CNT_W'(AMT_MAX_DIGITS);
            default:         w_max = CNT_W'(PIN_DIGITS);
        endcase
    end

    bcd_field_accumulator u_acc (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clr),
        .i_digit_vld  (w_digit && (w_in_field || r_state == ST_IDLE)),
        .i_digit      (key_code),
        .i_max_digits (w_max),
        .o_value      (w_val),
        .o_count      (w_cnt),
        .o_overflow   (w_ovf)
    );

    always_comb begin
        w_pass = 1'b0;
        case (r_state)
            ST_ACC:           w_pass = (w_val >= 17'd1) && (w_val <= 17'(ACC_MAX));
            ST_PIN, ST_NPIN:  w_pass = (w_cnt == CNT_W'(PIN_DIGITS));
            ST_OP:            w_pass = (w_val >= 17'(OP_BAL)) && (w_val <= 17'(OP_EXIT));
            ST_AMT:           w_pass = (w_cnt != '0) && (w_val <= 17'(AMT_MAX));
            default:          w_pass = 1'b0;
        endcase
    end

`ifdef ATM_ENTRY_TIMEOUT_EN
    logic [19:0] r_idle_cnt;

    // A key in the limit cycle counts as activity and wins over the abort.
    assign w_tmo = w_in_field && !key_valid && (r_idle_cnt == 20'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_idle_cnt <= '0;
        else if (key_valid || !w_in_field || w_tmo)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + 20'd1;
    end
`else
    assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_req_valid <= 1'b0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            r_tmo <= 1'b0;
            if (w_tmo) begin
                r_state <= ST_IDLE;
                r_req   <= '0;
                r_tmo   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_digit) begin
                            r_state     <= ST_ACC;
                            r_req.lang  <= language_sel;
                        end else if (key_valid && key_code == KEY_CANCEL) begin
                            r_req <= '0;
                        end
                    end
                    ST_REQ: begin
                        if (req_ready) begin
                            r_state     <= ST_IDLE;
                            r_req_valid <= 1'b0;
                            r_req       <= '0;
                        end
                    end
                    default: begin
                        if (key_valid) begin
                            if (w_digit) begin
                                r_err <= w_ovf;
                            end else if (key_code == KEY_CANCEL) begin
                                r_state <= ST_IDLE;
                                r_req   <= '0;
                            end else if (key_code == KEY_ENTER) begin
                                if (!w_pass) begin
                                    r_err <= 1'b1;
                                end else begin
                                    case (r_state)
                                        ST_ACC: begin
                                            r_req.acc <= w_val[3:0];
                                            r_state   <= ST_PIN;
                                        end
                                        ST_PIN: begin
                                            r_req.pin <= w_val[13:0];
                                            r_state   <= ST_OP;
                                        end
                                        ST_OP: begin
                                            r_req.op <= w_val[2:0];
                                            if (w_val[2:0] == OP_WDRAW || w_val[2:0] == OP_DEP) begin
                                                r_state <= ST_AMT;
                                            end else if (w_val[2:0] == OP_CHPIN) begin
                                                r_state <= ST_NPIN;
                                            end else begin
                                                r_state     <= ST_REQ;
                                                r_req_valid <= 1'b1;
                                            end
                                        end
                                        ST_AMT: begin
                                            r_req.amount <= w_val[15:0];
                                            r_state      <= ST_REQ;
                                            r_req_valid  <= 1'b1;
                                        end
                                        ST_NPIN: begin
                                            r_req.new_pin <= w_val[13:0];
                                            r_state       <= ST_REQ;
                                            r_req_valid   <= 1'b1;
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign req_valid     = r_req_valid;
    assign operation     = r_req.op;
    assign acc_num       = r_req.acc;
    assign pin           = r_req.pin;
    assign amount        = r_req.amount;
    assign new_pin       = r_req.new_pin;
    assign language      = r_req.lang;
    assign entry_state   = r_state;
    assign entry_error   = r_err;
    assign timeout_pulse = r_tmo;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboard bench for atm_keypad_entry: a digit-list reference model predicts states,
// error pulses and completed requests; a negedge monitor checks what the DUT presents.
module tb_atm_keypad_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        language_sel = 1'b0;
    logic        req_ready = 1'b0;
    logic        req_valid;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [13:0] pin;
    logic [15:0] amount;
    logic [13:0] new_pin;
    logic        language;
    logic [2:0]  entry_state;
    logic        entry_error;
    logic        timeout_pulse;

    atm_keypad_entry dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .language_sel(language_sel), .req_ready(req_ready), .req_valid(req_valid),
        .operation(operation), .acc_num(acc_num), .pin(pin), .amount(amount),
        .new_pin(new_pin), .language(language), .entry_state(entry_state),
        .entry_error(entry_error), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op; int acc; int pin; int amt; int npin; int lang;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   exp_err = 0;
    int   err_seen = 0;
    int   tmo_seen = 0;
    exp_t exp_q[$];

    // Reference model: phase number, typed digits, latched fields.
    int   m_phase = 0;
    int   m_dq[$];
    exp_t m_f = '{default: 0};
    int   sq[$];

    function automatic logic [51:0] pack(input exp_t e);
        int a, b, c, d, f, g;
        a = e.op; b = e.acc; c = e.pin; d = e.amt; f = e.npin; g = e.lang;
        return {a[2:0], b[3:0], c[13:0], d[15:0], f[13:0], g[0]};
    endfunction

    function automatic logic [51:0] fields();
        return {operation, acc_num, pin, amount, new_pin, language};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int limit(input int ph);
        case (ph)
            1: return 2;
            3: return 1;
            4: return 5;
            default: return 4;
        endcase
    endfunction

    task automatic model_key(input int k);
        int v, n;
        bit ok;
        if (m_phase == 0) begin
            if (k <= 9) begin
                m_phase = 1;
                m_dq = {k};
                m_f.lang = language_sel;
            end else if (k == 12) begin
                m_f = '{default: 0};
            end
        end else if (m_phase != 6) begin
            if (k <= 9) begin
                if (m_dq.size() >= limit(m_phase)) exp_err++;
                else m_dq.push_back(k);
            end else if (k == 11) begin
                m_dq.delete();
            end else if (k == 12) begin
                m_phase = 0;
                m_f = '{default: 0};
                m_dq.delete();
            end else if (k == 10) begin
                v = 0;
                foreach (m_dq[i]) v = v * 10 + m_dq[i];
                n = m_dq.size();
                m_dq.delete();
                case (m_phase)
                    1: ok = (v >= 1 && v <= 15);
                    2, 5: ok = (n == 4);
                    3: ok = (v >= 3 && v <= 7);
                    default: ok = (n >= 1 && v <= 65535);
                endcase
                if (!ok) exp_err++;
                else begin
                    case (m_phase)
                        1: begin m_f.acc = v; m_phase = 2; end
                        2: begin m_f.pin = v; m_phase = 3; end
                        3: begin
                            m_f.op = v;
                            m_phase = (v == 4 || v == 5) ? 4 : (v == 6) ? 5 : 6;
                        end
                        4: begin m_f.amt = v; m_phase = 6; end
                        default: begin m_f.npin = v; m_phase = 6; end
                    endcase
                    if (m_phase == 6) exp_q.push_back(m_f);
                end
            end
        end
    endtask

    task automatic press(input int k);
        @(negedge clk);
        language_sel = 1'($urandom_range(0, 1));
        key_code = k[3:0];
        key_valid = 1'b1;
        model_key(k);
        @(negedge clk);
        key_valid = 1'b0;
        chk("state", entry_state, m_phase);
        chk("req_valid", req_valid, (m_phase == 6));
    endtask

    task automatic run_sq();
        foreach (sq[i]) press(sq[i]);
    endtask

    task automatic chk_err(input string nm);
        @(negedge clk);
        #1;
        chk(nm, err_seen, exp_err);
    endtask

    task automatic handshake(input int nkeys, input bit key_in_hs);
        for (int i = 0; i < nkeys; i++) press($urandom_range(0, 15));
        @(negedge clk);
        req_ready = 1'b1;
        if (key_in_hs) begin
            key_valid = 1'b1;
            key_code = 4'($urandom_range(0, 9));
        end
        @(negedge clk);
        req_ready = 1'b0;
        key_valid = 1'b0;
        m_phase = 0;
        m_f = '{default: 0};
        chk("hs_valid", req_valid, 0);
        chk("hs_state", entry_state, 0);
        chk("hs_fields", fields(), 0);
    endtask

    task automatic type_num(input int v);
        if (v >= 10) press(v / 10);
        press(v % 10);
    endtask

    task automatic gen_step();
        int r, len;
        r = $urandom_range(0, 19);
        if (r == 0) press(11);
        else if (r == 1) press(12);
        else if (r == 2) press($urandom_range(13, 15));
        else if (r == 3) press($urandom_range(0, 9));
        else begin
            case (m_phase)
                0, 1: type_num($urandom_range(0, 18));
                2, 5: begin
                    len = ($urandom_range(0, 3) != 0) ? 4 : $urandom_range(3, 5);
                    for (int i = 0; i < len; i++) press($urandom_range(0, 9));
                end
                3: type_num($urandom_range(2, 8));
                default: begin
                    len = $urandom_range(0, 6);
                    for (int i = 0; i < len; i++) press($urandom_range(0, 9));
                end
            endcase
            press(10);
        end
    endtask

    // Monitor: each new request pops one expectation; held requests must not change.
    logic        prev_v = 1'b0;
    logic [51:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (entry_error) err_seen++;
        if (timeout_pulse) tmo_seen++;
        if (req_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL req_unexpected: got %0h expected none", fields());
            end else begin
                e = exp_q.pop_front();
                chk("req_fields", fields(), pack(e));
            end
            held = fields();
        end else if (req_valid) begin
            chk("req_stable", fields(), held);
        end
        prev_v = req_valid;
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_outs", {req_valid, fields(), entry_state, entry_error, timeout_pulse}, 0);
        rst = 1'b1;

        sq = '{14, 10, 11, 1, 10, 1, 2, 3, 4, 10, 3, 10};
        run_sq();
        chk_err("t1_err");
        handshake(0, 0);

        sq = '{5, 10, 5, 6, 7, 8, 10, 4, 10, 2, 5, 0, 10};
        run_sq();
        handshake(2, 0);

        sq = '{1, 10, 1, 2, 3, 10};
        run_sq();
        chk_err("short_pin_err");
        sq = '{1, 2, 3, 4, 5};
        run_sq();
        chk_err("pin_5th_digit_err");
        sq = '{10, 6, 10, 9, 12};
        run_sq();
        chk("cancel_zero", fields(), 0);

        sq = '{1, 6, 10};
        run_sq();
        chk_err("acc16_err");
        sq = '{9, 10, 1, 1, 1, 1, 10, 5, 10, 7, 0, 0, 0, 0, 10};
        run_sq();
        chk_err("amt70000_err");
        sq = '{6, 5, 5, 3, 6, 10, 6, 5, 5, 3, 5, 10};
        run_sq();
        chk_err("amt65535_err");
        handshake(5, 1);

        sq = '{2, 10, 4, 4, 4, 4, 10, 4, 10, 2, 5};
        run_sq();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", {req_valid, fields(), entry_state, entry_error, timeout_pulse}, 0);
        m_phase = 0;
        m_f = '{default: 0};
        m_dq.delete();
        @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 150; t++) begin
            n = 0;
            while (m_phase != 6 && n < 60) begin
                gen_step();
                n++;
            end
            if (m_phase == 6) handshake($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            else press(12);
        end

        chk_err("final_err");
        chk("queue_empty", exp_q.size(), 0);
        chk("no_timeouts", tmo_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
